i2c_reg_ctrl: RTL and testbench

//  Register-map controller on the i2c_slave data interface. First byte written after START is a

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_reg_bank.sv | 34 +++
 rtl/i2c_reg_ctrl.sv | 105 ++++++++++
 tb/tb_i2c_reg_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-map controller: FSM state encoding and
// the default bank depth.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PTR   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } i2c_reg_ctrl_state_t;

  localparam int I2C_NUM_REGS_DEF = 16;

endpackage

// File: rtl/i2c_reg_bank.sv
// NUM_REGS x 8 register bank. Two write ports (local port wins on address
// collision) and two combinational read ports (I2C pointer and local address).
module i2c_reg_bank import i2c_pkg::*; #(
  parameter int         NUM_REGS  = I2C_NUM_REGS_DEF,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i2c_we,
  input  logic [AW-1:0] i2c_addr,
  input  logic [7:0]    i2c_wdata,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    ptr_rdata,
  output logic [7:0]    loc_rdata
);

  logic [NUM_REGS-1:0][7:0] mem;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    // One entry: local write has priority over a same-cycle I2C write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                mem[i] <= RESET_VAL;
      else if (loc_we && loc_addr == AW'(i))     mem[i] <= loc_wdata;
      else if (i2c_we && i2c_addr == AW'(i))     mem[i] <= i2c_wdata;
    end
  end

  assign ptr_rdata = mem[i2c_addr];
  assign loc_rdata = mem[loc_addr];

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-map controller behind an I2C slave. First byte after START sets the
// register pointer, following bytes write the bank with auto-increment, reads
// stream bank[ptr] with auto-increment. Local port gives side access.
// Optional write protect input wp_i when I2C_REG_CTRL_WPROT_EN is defined.
module i2c_reg_ctrl import i2c_pkg::*; #(
  parameter int         NUM_REGS  = I2C_NUM_REGS_DEF,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          txn_start,
  input  logic          txn_stop,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  input  logic          loc_we,
  output logic [7:0]    loc_rdata,
`ifdef I2C_REG_CTRL_WPROT_EN
  input  logic          wp_i,
`endif
  output logic          wr_evt,
  output logic [AW-1:0] wr_evt_addr
);

  i2c_reg_ctrl_state_t state;
  logic [AW-1:0]       ptr;
  logic [7:0]          ptr_rdata;
  logic                wp;
  logic                i2c_we;

`ifdef I2C_REG_CTRL_WPROT_EN
  assign wp = wp_i;
`else
  assign wp = 1'b0;
`endif

  // A data byte only lands when no START/STOP overrides it in the same cycle.
  assign i2c_we = (state == WRITE) && rx_valid && !txn_stop && !txn_start && !wp;

  i2c_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2c_we    (i2c_we),
    .i2c_addr  (ptr),
    .i2c_wdata (rx_data),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .ptr_rdata (ptr_rdata),
    .loc_rdata (loc_rdata)
  );

  // Transaction FSM with pointer; tx_valid registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      tx_valid <= 1'b0;
    end else if (txn_stop) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
    end else if (txn_start) begin
      state    <= PTR;
      tx_valid <= 1'b1;
    end else begin
      case (state)
        PTR: begin
          if (rx_valid) begin
            state    <= WRITE;
            ptr      <= rx_data[AW-1:0];
            tx_valid <= 1'b0;
          end else if (tx_ready) begin
            state <= READ;
            ptr   <= ptr + 1'b1;
          end
        end
        WRITE: if (rx_valid) ptr <= ptr + 1'b1;
        READ:  if (tx_ready && !rx_valid) ptr <= ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Read byte tracks bank[ptr] one cycle behind; write event flags each landed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data     <= RESET_VAL;
      wr_evt      <= 1'b0;
      wr_evt_addr <= '0;
    end else begin
      tx_data <= ptr_rdata;
      wr_evt  <= i2c_we;
      if (i2c_we) wr_evt_addr <= ptr;
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with scoreboard queues for write events and
// read bytes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_i2c_reg_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          txn_start = 1'b0, txn_stop = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [AW-1:0] loc_addr = '0;
  logic [7:0]    loc_wdata = '0;
  logic          loc_we = 1'b0;
  logic [7:0]    loc_rdata;
  logic          wr_evt;
  logic [AW-1:0] wr_evt_addr;
`ifdef I2C_REG_CTRL_WPROT_EN
  logic          wp_i = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int exp_wr[$];
  int exp_rd[$];

  always #5 clk = ~clk;

  i2c_reg_ctrl #(.NUM_REGS(16), .RESET_VAL(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .txn_start   (txn_start),
    .txn_stop    (txn_stop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .loc_addr    (loc_addr),
    .loc_wdata   (loc_wdata),
    .loc_we      (loc_we),
    .loc_rdata   (loc_rdata),
`ifdef I2C_REG_CTRL_WPROT_EN
    .wp_i        (wp_i),
`endif
    .wr_evt      (wr_evt),
    .wr_evt_addr (wr_evt_addr)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write event and every consumed read byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_evt) begin
        if (exp_wr.size() == 0) chk("unexpected_wr_evt", int'(wr_evt_addr), -1);
        else chk("wr_evt_addr", int'(wr_evt_addr), exp_wr.pop_front());
      end
      if (tx_ready && tx_valid) begin
        if (exp_rd.size() == 0) chk("unexpected_tx", int'(tx_data), -1);
        else chk("tx_data", int'(tx_data), exp_rd.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start();
    txn_start = 1'b1; cyc(); txn_start = 1'b0;
  endtask

  task automatic stop();
    txn_stop = 1'b1; cyc(); txn_stop = 1'b0; cyc();
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; cyc(); rx_valid = 1'b0; cyc();
  endtask

  task automatic rxw(input logic [7:0] b, input int addr);
    exp_wr.push_back(addr); rx(b);
  endtask

  task automatic txr(input int exp);
    exp_rd.push_back(exp);
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0; cyc(2);
  endtask

  task automatic lw(input int a, input logic [7:0] d);
    loc_addr = AW'(a); loc_wdata = d; loc_we = 1'b1; cyc(); loc_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input int exp);
    loc_addr = AW'(a); #1; chk(name, int'(loc_rdata), exp);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    cyc();
    // reset state
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_wr_evt", int'(wr_evt), 0);
    chk("rst_wr_evt_addr", int'(wr_evt_addr), 0);
    rd_chk("rst_bank7", 7, 0);

    // pointer write then two data bytes
    start(); rx(8'h03); rxw(8'hA5, 3); rxw(8'h5A, 4); stop();
    rd_chk("bank3", 3, 8'hA5);
    rd_chk("bank4", 4, 8'h5A);
    chk("idle_tx_valid", int'(tx_valid), 0);
    // pointer persisted at 5
    lw(5, 8'hC5);
    start(); cyc(2);
    chk("ptr_tx_valid", int'(tx_valid), 1);
    txr(8'hC5); stop();

    // read with wrap 14,15,0 after repeated START
    lw(14, 8'hE1); lw(15, 8'hF2); lw(0, 8'h0A);
    start(); rx(8'h0E); start(); cyc(2);
    txr(8'hE1); txr(8'hF2); txr(8'h0A); stop();

    // pointer upper bits ignored
    start(); rx(8'h27); rxw(8'h11, 7); stop();
    rd_chk("bank7", 7, 8'h11);

    // same-address collision: local data wins, event still fires
    start(); rx(8'h02);
    loc_addr = 4'd2; loc_wdata = 8'h99; loc_we = 1'b1;
    exp_wr.push_back(2); rx_data = 8'h44; rx_valid = 1'b1;
    cyc(); loc_we = 1'b0; rx_valid = 1'b0; cyc(); stop();
    rd_chk("collide_same", 2, 8'h99);
    // different addresses: both land
    start(); rx(8'h08);
    loc_addr = 4'd9; loc_wdata = 8'h77; loc_we = 1'b1;
    exp_wr.push_back(8); rx_data = 8'h66; rx_valid = 1'b1;
    cyc(); loc_we = 1'b0; rx_valid = 1'b0; cyc(); stop();
    rd_chk("collide_i2c", 8, 8'h66);
    rd_chk("collide_loc", 9, 8'h77);

    // stop beats rx_valid; tx_ready in IDLE leaves ptr alone
    lw(10, 8'h3C);
    start(); rx(8'h0A);
    rx_data = 8'hBB; rx_valid = 1'b1; txn_stop = 1'b1;
    cyc(); rx_valid = 1'b0; txn_stop = 1'b0; cyc();
    rd_chk("stop_no_write", 10, 8'h3C);
    chk("stop_tx_valid", int'(tx_valid), 0);
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0; cyc();
    start(); cyc(2); txr(8'h3C); stop();

`ifdef I2C_REG_CTRL_WPROT_EN
    // write protect: no bank write, no event, pointer still moves
    wp_i = 1'b1;
    start(); rx(8'h01); rx(8'hFF); stop();
    wp_i = 1'b0;
    rd_chk("wp_bank1", 1, 8'h00);
    start(); cyc(2); txr(8'h99); stop();
`endif

    // async reset mid-transaction
    start(); rx(8'h0C);
    #3 rst_n = 1'b0; #1;
    chk("mid_rst_tx_valid", int'(tx_valid), 0);
    rd_chk("mid_rst_bank3", 3, 0);
    chk("mid_rst_wr_evt_addr", int'(wr_evt_addr), 0);
    #10 rst_n = 1'b1;
    cyc(2);

    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
